// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline-stage registers.
//   - EX/MEM payload field offsets (bit 0 is the MSB of the payload word).
//   - PIPE_EXMEM_W: width of the EX/MEM payload word.
//   - ptr_width / count_width: helper sizing functions for the ring buffer.
package pipe_pkg;

    localparam int PIPE_EXMEM_W = 180;

    // EX/MEM payload layout, [0:PIPE_EXMEM_W-1] ordering.
    localparam int EXMEM_NEXTPC_LO = 0;
    localparam int EXMEM_NEXTPC_HI = 31;
    localparam int EXMEM_OPB_LO    = 32;
    localparam int EXMEM_OPB_HI    = 63;
    localparam int EXMEM_DEST_LO   = 64;
    localparam int EXMEM_DEST_HI   = 68;
    localparam int EXMEM_ALU_LO    = 69;
    localparam int EXMEM_ALU_HI    = 100;
    localparam int EXMEM_CTRL_LO   = 101;
    localparam int EXMEM_CTRL_HI   = 108;
    localparam int EXMEM_LEAP_LO   = 109;
    localparam int EXMEM_LEAP_HI   = 141;
    localparam int EXMEM_MEMVAL_LO = 142;
    localparam int EXMEM_MEMVAL_HI = 173;
    localparam int EXMEM_RS2_LO    = 174;
    localparam int EXMEM_RS2_HI    = 178;
    localparam int EXMEM_TRAP      = 179;

    // Pointer width; a single-entry ring still needs a 1-bit pointer.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_ring_ptr.sv
// Read/write pointer, occupancy count and flush-pulse bookkeeping for a
// DEPTH-entry circular buffer.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   push, pop         qualified transfer strobes (already exclude flush)
//   flush             discard everything held
//   rd_ptr, wr_ptr    ring indices 0..DEPTH-1
//   count             occupancy 0..DEPTH
//   flushed           one-cycle pulse after a flush that dropped entries
module pipe_ring_ptr
    import pipe_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = ptr_width(DEPTH),
    localparam int CNT_W = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [CNT_W-1:0] count,
    output logic             flushed
);

    // Wrap DEPTH-1 -> 0; DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            flushed <= 1'b0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            flushed <= (count != '0);
        end else begin
            flushed <= 1'b0;
            if (push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            // Simultaneous push and pop cancel out.
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register: a DEPTH-entry FIFO between two pipeline
// stages with flush-to-bubble and an occupancy count.
//
// Handshake: a word moves on a side only in a cycle where both valid and
// ready are high at the rising edge; valid never depends on ready on the
// same side, and a flush in that cycle cancels both transfers.
//
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   in_valid     upstream offers in_data
//   in_ready     stage accepts this cycle
//   in_data      payload from upstream, [0:WIDTH-1]
//   flush        discard all held entries (wins over push and pop)
//   out_valid    head entry valid
//   out_ready    downstream consumes the head
//   out_data     head payload, BUBBLE while empty
//   count        current occupancy
//   flushed      one-cycle pulse: a flush discarded at least one entry
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter  int               WIDTH  = PIPE_EXMEM_W,
    parameter  int               DEPTH  = 2,
    parameter  logic [0:WIDTH-1] BUBBLE = '0,
    localparam int               PTR_W  = ptr_width(DEPTH),
    localparam int               CNT_W  = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:WIDTH-1] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:WIDTH-1] out_data,
    output logic [CNT_W-1:0] count,
    output logic             flushed
);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push;
    logic             pop;

    // Sized to the full pointer range so every pointer value indexes a real
    // entry; entries at or beyond DEPTH are never written or read.
    logic [0:WIDTH-1] mem [2**PTR_W];

    assign out_valid = (count != '0);

    generate
        if (DEPTH == 1) begin : g_ready_pass
            // Single entry: accept when the entry leaves in the same cycle.
            assign in_ready = ~out_valid | out_ready;
        end else begin : g_ready_reg
            // Registered-state only; breaks the ready chain.
            assign in_ready = (count != CNT_W'(DEPTH));
        end
    endgenerate

    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    pipe_ring_ptr #(
        .DEPTH (DEPTH)
    ) u_ring_ptr (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .rd_ptr  (rd_ptr),
        .wr_ptr  (wr_ptr),
        .count   (count),
        .flushed (flushed)
    );

    // Storage is intentionally not reset; out_data masks it while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    assign out_data = out_valid ? mem[rd_ptr] : BUBBLE;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
module tb_pipe_stage_elastic;
    import pipe_pkg::*;

    localparam int W = PIPE_EXMEM_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    // ---------------- DUT a: DEPTH=2 ----------------
    logic         a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready, a_flushed;
    logic [0:W-1] a_in_data, a_out_data;
    logic [1:0]   a_count;

    pipe_stage_elastic #(.WIDTH(W), .DEPTH(2)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .flush     (a_flush),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .count     (a_count),
        .flushed   (a_flushed)
    );

    // ---------------- DUT b: DEPTH=1 ----------------
    logic         b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_flushed;
    logic [0:W-1] b_in_data, b_out_data;
    logic [0:0]   b_count;

    pipe_stage_elastic #(.WIDTH(W), .DEPTH(1)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .flush     (b_flush),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .count     (b_count),
        .flushed   (b_flushed)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] a_model[$];   // words the stage should hold
    logic [W-1:0] a_exp_q[$];   // words still expected on the output
    logic [W-1:0] b_model[$];
    logic [W-1:0] b_exp_q[$];
    bit           a_fl_exp, b_fl_exp;
    bit           armed = 1'b0;
    int           tests = 0;
    int           fails = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rnd_word();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i += 32) r = (r << 32) | W'($urandom);
        return r;
    endfunction

    // Reference model: evaluated at each rising edge from the stage rules.
    initial forever begin
        @(posedge clk);
        if (reset) begin
            a_model.delete(); a_exp_q.delete(); a_fl_exp = 1'b0;
            b_model.delete(); b_exp_q.delete(); b_fl_exp = 1'b0;
        end else begin
            // DEPTH=2: accept while fewer than two words held.
            if (a_flush) begin
                a_fl_exp = (a_model.size() != 0);
                a_model.delete(); a_exp_q.delete();
            end else begin
                bit acc;
                a_fl_exp = 1'b0;
                acc = a_in_valid && (a_model.size() < 2);
                if (a_model.size() != 0 && a_out_ready) void'(a_model.pop_front());
                if (acc) begin
                    a_model.push_back(a_in_data);
                    a_exp_q.push_back(a_in_data);
                end
            end
            // DEPTH=1: accept when empty or the held word leaves now.
            if (b_flush) begin
                b_fl_exp = (b_model.size() != 0);
                b_model.delete(); b_exp_q.delete();
            end else begin
                bit acc;
                b_fl_exp = 1'b0;
                acc = b_in_valid && (b_model.size() == 0 || b_out_ready);
                if (b_model.size() != 0 && b_out_ready) void'(b_model.pop_front());
                if (acc) begin
                    b_model.push_back(b_in_data);
                    b_exp_q.push_back(b_in_data);
                end
            end
        end
    end

    // Monitor: samples on the falling edge, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (armed) begin
            chk("a_count", W'(a_count), W'(a_model.size()));
            chk("a_out_valid", W'(a_out_valid), W'(a_model.size() != 0));
            chk("a_in_ready", W'(a_in_ready), W'(a_model.size() < 2));
            chk("a_flushed", W'(a_flushed), W'(a_fl_exp));
            if (a_model.size() == 0) chk("a_bubble", a_out_data, '0);
            if (a_out_valid && a_out_ready && !a_flush && !reset) begin
                if (a_exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL a_unexpected_out: got %0h expected no word", a_out_data);
                end else begin
                    chk("a_data", a_out_data, a_exp_q.pop_front());
                end
            end

            chk("b_count", W'(b_count), W'(b_model.size()));
            chk("b_out_valid", W'(b_out_valid), W'(b_model.size() != 0));
            chk("b_in_ready", W'(b_in_ready), W'(b_model.size() == 0 || b_out_ready));
            chk("b_flushed", W'(b_flushed), W'(b_fl_exp));
            if (b_model.size() == 0) chk("b_bubble", b_out_data, '0);
            if (b_out_valid && b_out_ready && !b_flush && !reset) begin
                if (b_exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL b_unexpected_out: got %0h expected no word", b_out_data);
                end else begin
                    chk("b_data", b_out_data, b_exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a word until the stage takes it; returns cycles spent.
    task automatic push_a(input logic [W-1:0] d, output int cyc);
        bit acc;
        cyc = 0;
        a_in_valid = 1'b1;
        a_in_data  = d;
        do begin
            @(negedge clk);
            acc = a_in_ready && !a_flush;
            tick();
            cyc++;
        end while (!acc && cyc < 50);
        if (!acc) begin
            tests++; fails++;
            $display("FAIL a_push_timeout: got no accept expected accept within 50 cycles");
        end
    endtask

    task automatic push_b(input logic [W-1:0] d, output int cyc);
        bit acc;
        cyc = 0;
        b_in_valid = 1'b1;
        b_in_data  = d;
        do begin
            @(negedge clk);
            acc = b_in_ready && !b_flush;
            tick();
            cyc++;
        end while (!acc && cyc < 50);
        if (!acc) begin
            tests++; fails++;
            $display("FAIL b_push_timeout: got no accept expected accept within 50 cycles");
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c;
        reset = 1'b1;
        a_in_valid = 1'b0; a_in_data = '0; a_flush = 1'b0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_flush = 1'b0; b_out_ready = 1'b0;
        tick();
        armed = 1'b1;
        tick();
        reset = 1'b0;
        repeat (3) tick();

        // Fill DEPTH=2 while blocked; third word must wait upstream.
        push_a(W'(32'hA), c);
        push_a(W'(32'hB), c);
        fork
            begin
                push_a(W'(32'hC), c);
                chk("a_c_held", W'(c > 1), W'(1));
                a_in_valid = 1'b0;
            end
            begin
                repeat (4) tick();
                chk("a_full_count", W'(a_count), W'(2));
                a_out_ready = 1'b1;
            end
        join
        repeat (5) tick();

        // Sustained one word per cycle.
        for (int i = 1; i <= 16; i++) begin
            push_a(W'(i), c);
            chk("a_rate", W'(c), W'(1));
            chk("a_cnt_le1", W'(a_count <= 2'd1), W'(1));
        end
        a_in_valid = 1'b0;
        repeat (3) tick();

        // Flush at count=2 with a concurrent push and pop.
        a_out_ready = 1'b0;
        push_a(W'(32'h1), c);
        push_a(W'(32'h2), c);
        a_in_data   = W'(32'h55);
        a_out_ready = 1'b1;
        a_flush     = 1'b1;
        tick();
        a_flush = 1'b0;
        a_in_valid = 1'b0;
        chk("a_flush_count", W'(a_count), W'(0));
        chk("a_flush_pulse", W'(a_flushed), W'(1));
        chk("a_flush_bubble", a_out_data, '0);
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        chk("a_flush_empty_pulse", W'(a_flushed), W'(0));
        repeat (3) tick();

        // Reset while holding two words.
        a_out_ready = 1'b0;
        push_a(W'(32'h11), c);
        push_a(W'(32'h22), c);
        a_in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("a_rst_count", W'(a_count), W'(0));
        chk("a_rst_valid", W'(a_out_valid), W'(0));
        chk("a_rst_flushed", W'(a_flushed), W'(0));
        push_a(W'(32'h7), c);
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        tick();
        repeat (3) tick();

        // DEPTH=1 with out_ready toggling 1,0,1.
        fork
            begin
                for (int i = 0; i < 12; i++) push_b(W'(32'h100 + i), c);
                b_in_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 36; k++) begin
                    b_out_ready = (k % 3 != 1);
                    tick();
                end
            end
        join
        b_out_ready = 1'b1;
        repeat (3) tick();

        // Randomised traffic on both stages.
        repeat (400) begin
            a_in_valid  = 1'($urandom_range(0, 1));
            a_in_data   = rnd_word();
            a_out_ready = 1'($urandom_range(0, 1));
            a_flush     = ($urandom_range(0, 19) == 0);
            b_in_valid  = 1'($urandom_range(0, 1));
            b_in_data   = rnd_word();
            b_out_ready = 1'($urandom_range(0, 1));
            b_flush     = ($urandom_range(0, 19) == 0);
            tick();
        end
        a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b1;
        repeat (4) tick();
        chk("a_drained", W'(a_exp_q.size()), W'(0));
        chk("b_drained", W'(b_exp_q.size()), W'(0));

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_stage_elastic.md
# pipe_stage_elastic

Parametrised elastic pipeline-stage register: successor to the fixed-width flush-only stage registers between IF/ID/EX/MEM/WB. Holds up to DEPTH in-flight payload words with a valid/ready handshake on both sides, flush to bubble, and an occupancy count. Stages can stall independently of their neighbours. The DEPTH=1 instance replaces a plain stage register; the DEPTH>=2 instances cut the combinational ready chain across the pipeline.

## Interface
- WIDTH, 180: payload width; bit 0 is the MSB, `[0:WIDTH-1]` ordering.
- DEPTH, 2: entries held, 1..8.
- BUBBLE, {WIDTH{1'b0}}: value driven on out_data while empty. All-zero means no RegWrite/MemWrite/trap, i.e. a NOP.
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  upstream offers in_data.
- in_ready  out  1  stage accepts this cycle.
- in_data  in  WIDTH  payload from upstream.
- flush  in  1  discard all held entries.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  downstream consumes the head.
- out_data  out  WIDTH  head payload, or BUBBLE when empty.
- count  out  clog2(DEPTH+1)  current occupancy.
- flushed  out  1  one-cycle pulse: a flush discarded at least one entry.

## Operation
- Push = in_valid & in_ready & ~flush. Pop = out_valid & out_ready & ~flush.
- Storage is a circular buffer with rd_ptr, wr_ptr (0..DEPTH-1, wrap DEPTH-1→0) and count.
- Push writes in_data at wr_ptr and advances wr_ptr.
- Pop advances rd_ptr.
- Count update: count += push - pop. A simultaneous push and pop leaves count unchanged; this is legal only when 0<count or DEPTH=1 with the entry held.
- in_ready:
  - DEPTH=1: ~out_valid | out_ready. This combinational path is allowed only for this case.
  - DEPTH>=2: count<DEPTH. It is a function of registered state only, with no path from out_ready.
- out_valid = count!=0. out_data = mem[rd_ptr] when out_valid, else BUBBLE.
- Flush:
  - Next cycle, count=0, rd_ptr=wr_ptr=0, out_valid=0 and out_data=BUBBLE.
  - Flush wins over any push or pop in the same cycle; that push is dropped and the pop does not occur.
  - flushed=1 on the next cycle iff count!=0 at the flush edge.
- Full (count=DEPTH, DEPTH>=2): in_ready=0 and in_data is ignored. A pop in that cycle frees the slot only from the next cycle.
- Empty: a pop cannot occur. A push makes out_valid=1 on the next cycle; there is no same-cycle bypass.
- Storage contents are not reset. Only the pointers, count and flushed are reset. Since out_data is muxed to BUBBLE while empty, X never reaches out_data.

## Timing
- Reset (reset=1 at edge): count=0, pointers=0, out_valid=0, out_data=BUBBLE, flushed=0. in_ready is 1 after reset.
- reset asserted mid-operation discards all entries without pulsing flushed.
- Latency: a word pushed at edge N appears on out_data with out_valid=1 after edge N. Downstream may consume it in cycle N+1.
- Throughput: one word per cycle sustained for every DEPTH while out_ready=1.
  - DEPTH=1 reaches this through the pass-through ready.
  - DEPTH>=2 reaches this because count never hits DEPTH.
- Ordering: strict FIFO; no reordering or duplication.

## Structure
- Shared package `pipe_pkg`:
  - EX/MEM field offset localparams: NEXTPC 0..31, OPB 32..63, DEST 64..68, ALU 69..100, control bits 101..108, LEAP 109..141, MEMVAL 142..173, RS2 174..178, TRAP 179.
  - `PIPE_EXMEM_W = 180`.
- Sub-module `pipe_ring_ptr`: holds pointer wrap and count logic for DEPTH.
- The storage array stays in the top module.

## Test plan
- Reset, then idle: out_valid=0, out_data=BUBBLE (0), count=0, in_ready=1, flushed=0.
- DEPTH=2, push 0xA,0xB,0xC on consecutive cycles with out_ready=0:
  - 0xA and 0xB are accepted, count=2, in_ready=0, and 0xC is held by upstream.
  - Raising out_ready then yields 0xA, 0xB, 0xC in order.
- DEPTH=2, continuous push of 1..16 with out_ready=1: 16 outputs on consecutive cycles, count≤1 throughout.
- Flush with count=2 while also pushing 0x55 and popping:
  - Next cycle count=0, out_data=BUBBLE, flushed=1.
  - 0x55 never appears.
  - A flush at count=0 gives flushed=0.
- DEPTH=1, out_ready toggling 1,0,1 with in_valid=1: in_ready follows ~out_valid|out_ready, with no lost or duplicated words.
- Reset asserted with count=2: next cycle count=0, out_valid=0, flushed=0; a subsequent push of 0x7 emerges first.
